hazard_flush_ctrl: RTL and testbench
====================================

// Module: hazard_flush_ctrl
// PURPOSE
//   Pipeline sequencer for the ID/EX -> EX -> EX/MEM datapath. Detects load-use hazards
//   (load in EX, dependent instruction in ID) and inserts a one-cycle bubble. Detects taken
//   branches resolved at EX/MEM (branch & zero) and flushes the younger stages.
//   Keeps saturating stall and flush event counters for performance debug.
// PARAMETERS
//   REG_AW  5   register-index width
//   CNT_W   16  width of stall_count / flush_count
// PORTS
//   clk          in   1       clock, all state updates on rising edge
//   rst          in   1       synchronous, active-high reset
//   hold         in   1       external freeze (e.g. memory wait); pipeline fully held
//   id_rs1       in   REG_AW  rs1 of instruction in ID
//   id_rs2       in   REG_AW  rs2 of instruction in ID
//   id_uses_rs2  in   1       ID instruction reads rs2 (R/S/B types)
//   ex_memread   in   1       ID/EX memread (load in EX)
//   ex_rd        in   REG_AW  ID/EX destination register
//   mem_branch   in   1       EX/MEM branch flag
//   mem_zero     in   1       EX/MEM zero flag
//   pc_write     out  1       PC register enable
//   ifid_write   out  1       IF/ID register enable
//   idex_bubble  out  1       zero ID/EX control fields this cycle
//   flush        out  1       clear IF/ID, ID/EX, EX/MEM valid/control this cycle
//   pc_sel       out  1       1 = next PC from EX/MEM branch target, 0 = PC+4
//   state        out  2       FSM state: 0 RUN, 1 STALL, 2 FLUSH
//   stall_count  out  CNT_W  number of bubbles inserted (saturating)
//   flush_count  out  CNT_W  number of taken-branch flushes (saturating)
// BEHAVIOUR
//   Hazard terms (combinational, same cycle):
//   - taken = mem_branch & mem_zero & ~hold & (state != FLUSH)
//   - lu    = ex_memread & (ex_rd != 0) & (ex_rd == id_rs1 | (id_uses_rs2 & ex_rd == id_rs2))
//             & ~hold & (state == RUN)
//   - stall = lu & ~taken. Branch has priority; the flushed load-user is discarded, no bubble.
//   Outputs (combinational from state and inputs; all forced to 0 while rst=1):
//   - pc_write = ifid_write = ~hold & ~stall
//   - idex_bubble = stall
//   - flush = pc_sel = taken
//   - hold=1: pc_write=ifid_write=0, idex_bubble=flush=pc_sel=0
//   FSM (registered; reset -> RUN):
//   - hold=1: state unchanged, counters unchanged, regardless of other inputs.
//   - RUN:   taken -> FLUSH; else stall -> STALL; else RUN.
//   - STALL: taken -> FLUSH; else RUN. The load-use check is masked for this cycle
//            (ID/EX holds a bubble), so back-to-back stalls are impossible.
//   - FLUSH: -> RUN. Both the branch check and the load-use check are masked for
//            this cycle (the stages contain squashed instructions).
//   - Encoding 3 is illegal; it must recover to RUN on the next edge.
//   Counters:
//   - stall_count += 1 on each edge where stall=1.
//   - flush_count += 1 on each edge where taken=1.
//   - Each counter saturates at 2^CNT_W-1 and never wraps.
//   Reset: state=RUN and both counters=0 on the first rising edge with rst=1.
//   - Reset mid-STALL or mid-FLUSH abandons the sequence; no pending event is counted.
//   Latency: hazard responses act in the same cycle; state and counters update one edge later.
// TESTING
//   1. ex_memread=1, ex_rd=5, id_rs1=5 in RUN -> idex_bubble=1, pc_write=0; next edge
//      state=STALL, stall_count=1; following cycle pc_write=1 with the same inputs.
//   2. ex_memread=1, ex_rd=0, id_rs1=0; and ex_rd=7, id_rs2=7, id_uses_rs2=0
//      -> no stall in either case, state stays RUN.
//   3. mem_branch=1, mem_zero=1 together with test-1 hazard -> flush=1, pc_sel=1,
//      idex_bubble=0, pc_write=1; next edge state=FLUSH, flush_count=1; the next cycle
//      with identical inputs gives flush=0, stall=0, then state=RUN.
//   4. hold=1 with taken branch and hazard inputs for 3 cycles -> all enables 0,
//      flush=0, state and counters unchanged; on hold=0 the branch is taken.
//   5. CNT_W=4, 20 separated load-use hazards -> stall_count saturates at 15.
//      mem_branch=1, mem_zero=0 -> no flush.
//   6. rst=1 asserted while in STALL with stall_count=3 -> after edge state=RUN,
//      counters=0; outputs are 0 while rst=1.

Source files
------------

// File: rtl/hazard_flush_ctrl.sv
// Pipeline sequencer: load-use bubble insertion and taken-branch flush, with event counters.
// Latency: hazard responses are combinational (same cycle); state and counters update one edge later.
// Backpressure: hold freezes the whole pipeline; no enables, no flush, no state or counter change.
module hazard_flush_ctrl #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hold,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_uses_rs2,
   input  logic              ex_memread,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              mem_branch,
   input  logic              mem_zero,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              idex_bubble,
   output logic              flush,
   output logic              pc_sel,
   output logic [1:0]        state,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      STALL   = 2'd1,
      FLUSH   = 2'd2,
      ILLEGAL = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t cur_state;
   state_t nxt_state;
   logic   taken;
   logic   lu;
   logic   stall;
   logic   rd_match;

   assign state = cur_state;

   // Hazard terms; the FLUSH cycle masks the branch check because the stages hold squashed work,
   // and only RUN may raise a load-use bubble (STALL already holds one in ID/EX).
   always_comb begin
      rd_match = (ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2));
      taken    = mem_branch & mem_zero & ~hold & (cur_state != FLUSH);
      lu       = ex_memread & (ex_rd != '0) & rd_match & ~hold & (cur_state == RUN);
      stall    = lu & ~taken;
   end

   // Pipeline control outputs, all quiet while reset is asserted.
   always_comb begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b0;
      flush       = 1'b0;
      pc_sel      = 1'b0;
      if (!rst) begin
         pc_write    = ~hold & ~stall;
         ifid_write  = ~hold & ~stall;
         idex_bubble = stall;
         flush       = taken;
         pc_sel      = taken;
      end
   end

   // Next-state logic; branch beats load-use, and the unused encoding always returns to RUN.
   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         RUN: begin
            if (!hold) begin
               if (taken)      nxt_state = FLUSH;
               else if (stall) nxt_state = STALL;
               else            nxt_state = RUN;
            end
         end
         STALL: begin
            if (!hold) nxt_state = taken ? FLUSH : RUN;
         end
         FLUSH: begin
            if (!hold) nxt_state = RUN;
         end
         default: nxt_state = RUN;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) cur_state <= RUN;
      else     cur_state <= nxt_state;
   end

   // Saturating event counters; stall/taken are already zero under hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (stall && stall_count != CNT_MAX) stall_count <= stall_count + 1'b1;
         if (taken && flush_count != CNT_MAX) flush_count <= flush_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Bench for hazard_flush_ctrl: table of per-cycle vectors plus a saturation sequence.
// Expected values are queued when a cycle is driven and checked at the following falling edge.
// Counters use CNT_W=4 so saturation is reachable in a short run.
module tb_hazard_flush_ctrl;

   localparam int REG_AW = 5;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst, hold, id_uses_rs2, ex_memread, mem_branch, mem_zero;
   logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
   logic              pc_write, ifid_write, idex_bubble, flush, pc_sel;
   logic [1:0]        state;
   logic [CNT_W-1:0]  stall_count, flush_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hazard_flush_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .hold(hold),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
      .ex_memread(ex_memread), .ex_rd(ex_rd),
      .mem_branch(mem_branch), .mem_zero(mem_zero),
      .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
      .flush(flush), .pc_sel(pc_sel), .state(state),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   typedef struct {
      logic              rst, hold, uses2, memrd, br, zr;
      logic [REG_AW-1:0] rs1, rs2, rd;
      logic              pcw, bub, fl;
      logic [1:0]        st;
      logic [CNT_W-1:0]  sc, fc;
   } vec_t;

   typedef struct {
      logic             pcw, bub, fl;
      logic [1:0]       st;
      logic [CNT_W-1:0] sc, fc;
      int               idx;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[22];

   function automatic vec_t mk(input logic r, input logic h, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic u2, input logic mr,
                               input logic [4:0] rd, input logic br, input logic zr,
                               input logic pcw, input logic bub, input logic fl,
                               input logic [1:0] st, input int sc, input int fc);
      vec_t v;
      v.rst = r;  v.hold = h; v.rs1 = rs1; v.rs2 = rs2; v.uses2 = u2; v.memrd = mr;
      v.rd = rd;  v.br = br;  v.zr = zr;   v.pcw = pcw; v.bub = bub;  v.fl = fl;
      v.st = st;  v.sc = CNT_W'(sc); v.fc = CNT_W'(fc);
      return v;
   endfunction

   task automatic check1(input string name, input int idx, input logic [CNT_W-1:0] act,
                         input logic [CNT_W-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s row=%0d actual=%0d required=%0d", name, idx, act, req);
      end
   endtask

   // Drive one cycle, queue its expectations, then compare at the falling edge.
   task automatic run_vec(input vec_t v, input int idx);
      exp_t e;
      rst = v.rst; hold = v.hold; id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs2 = v.uses2;
      ex_memread = v.memrd; ex_rd = v.rd; mem_branch = v.br; mem_zero = v.zr;
      e.pcw = v.pcw; e.bub = v.bub; e.fl = v.fl; e.st = v.st; e.sc = v.sc; e.fc = v.fc;
      e.idx = idx;
      sb.push_back(e);
      @(negedge clk);
      if (sb.size() == 0) begin
         total++; bad++;
         $display("FAIL scoreboard_empty row=%0d actual=0 required=1", idx);
      end else begin
         e = sb.pop_front();
         check1("pc_write",    e.idx, CNT_W'(pc_write),    CNT_W'(e.pcw));
         check1("ifid_write",  e.idx, CNT_W'(ifid_write),  CNT_W'(e.pcw));
         check1("idex_bubble", e.idx, CNT_W'(idex_bubble), CNT_W'(e.bub));
         check1("flush",       e.idx, CNT_W'(flush),       CNT_W'(e.fl));
         check1("pc_sel",      e.idx, CNT_W'(pc_sel),      CNT_W'(e.fl));
         check1("state",       e.idx, CNT_W'(state),       CNT_W'(e.st));
         check1("stall_count", e.idx, stall_count,         e.sc);
         check1("flush_count", e.idx, flush_count,         e.fc);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sc_exp;
      //               rst h rs1 rs2 u2 mr rd br zr | pcw bub fl st sc fc
      tbl[0]  = mk(1, 0,  5,  0, 0, 1, 5, 1, 1,   0, 0, 0, 0, 0, 0); // reset quiets outputs
      tbl[1]  = mk(0, 0,  5,  0, 0, 1, 5, 0, 0,   0, 1, 0, 0, 0, 0); // load-use on rs1
      tbl[2]  = mk(0, 0,  5,  0, 0, 1, 5, 0, 0,   1, 0, 0, 1, 1, 0); // masked in STALL
      tbl[3]  = mk(0, 0,  0,  0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 1, 0); // rd=0 never stalls
      tbl[4]  = mk(0, 0,  0,  7, 0, 1, 7, 0, 0,   1, 0, 0, 0, 1, 0); // rs2 unused
      tbl[5]  = mk(0, 0,  0,  7, 1, 1, 7, 0, 0,   0, 1, 0, 0, 1, 0); // rs2 used -> stall
      tbl[6]  = mk(0, 0,  0,  0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 2, 0);
      tbl[7]  = mk(0, 0,  5,  0, 0, 1, 5, 1, 1,   1, 0, 1, 0, 2, 0); // branch beats hazard
      tbl[8]  = mk(0, 0,  5,  0, 0, 1, 5, 1, 1,   1, 0, 0, 2, 2, 1); // FLUSH masks both
      tbl[9]  = mk(0, 0,  0,  0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 2, 1);
      tbl[10] = mk(0, 0,  0,  0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 2, 1); // not-taken branch
      tbl[11] = mk(0, 1,  5,  0, 0, 1, 5, 1, 1,   0, 0, 0, 0, 2, 1); // hold x3
      tbl[12] = mk(0, 1,  5,  0, 0, 1, 5, 1, 1,   0, 0, 0, 0, 2, 1);
      tbl[13] = mk(0, 1,  5,  0, 0, 1, 5, 1, 1,   0, 0, 0, 0, 2, 1);
      tbl[14] = mk(0, 0,  5,  0, 0, 1, 5, 1, 1,   1, 0, 1, 0, 2, 1); // released: taken
      tbl[15] = mk(0, 0,  0,  0, 0, 0, 0, 0, 0,   1, 0, 0, 2, 2, 2);
      tbl[16] = mk(0, 0,  5,  0, 0, 1, 5, 0, 0,   0, 1, 0, 0, 2, 2);
      tbl[17] = mk(0, 0,  5,  0, 0, 1, 5, 1, 1,   1, 0, 1, 1, 3, 2); // branch from STALL
      tbl[18] = mk(0, 0,  0,  0, 0, 0, 0, 0, 0,   1, 0, 0, 2, 3, 3);
      tbl[19] = mk(0, 0,  5,  0, 0, 1, 5, 0, 0,   0, 1, 0, 0, 3, 3);
      tbl[20] = mk(1, 0,  5,  0, 0, 1, 5, 1, 1,   0, 0, 0, 1, 4, 3); // reset mid-STALL
      tbl[21] = mk(0, 0,  0,  0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);

      rst = 1; hold = 0; id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 0;
      ex_memread = 0; ex_rd = '0; mem_branch = 0; mem_zero = 0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 22; i++) run_vec(tbl[i], i);

      // Hold while in FLUSH: state must stay FLUSH, then return to RUN.
      run_vec(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,   1, 0, 1, 0, 0, 0), 100);
      run_vec(mk(0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 2, 0, 1), 101);
      run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 2, 0, 1), 102);
      run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1), 103);

      // 20 separated load-use hazards: stall_count saturates at 15.
      sc_exp = 0;
      for (int k = 0; k < 20; k++) begin
         run_vec(mk(0, 0, 9, 0, 0, 1, 9, 1, 0,   0, 1, 0, 0, sc_exp, 1), 200 + 2 * k);
         if (sc_exp < 15) sc_exp++;
         run_vec(mk(0, 0, 0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 1, sc_exp, 1), 201 + 2 * k);
      end
      run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 15, 1), 300);

      if (sb.size() != 0) begin
         total++; bad++;
         $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
